// File: rtl/cpu_rf_pkg.sv
// rtl/cpu_rf_pkg.sv - shared constants and types for the register file port master
package cpu_rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADR_W  = 2;
  localparam int NREG   = 1 << ADR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic [NREG-1:0] busy_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy tracking with writeback-aware hazard queries
module rf_scoreboard
  import cpu_rf_pkg::*;
#(
  parameter int AW = cpu_rf_pkg::ADR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_adr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_adr,
  input  logic [AW-1:0] q1_adr,
  input  logic [AW-1:0] q2_adr,
  output logic          hazard1,
  output logic          hazard2
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] busy;
  logic [NR-1:0] busy_n;

  // Clear first, then set, so a same-cycle set to the same register survives.
  always_comb begin
    busy_n = busy;
    if (clr_en) busy_n[clr_adr] = 1'b0;
    if (set_en) busy_n[set_adr] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (!reset) busy <= '0;
    else        busy <= busy_n;
  end

  // A writeback landing this cycle resolves the hazard for its register.
  assign hazard1 = busy[q1_adr] && !(clr_en && (clr_adr == q1_adr));
  assign hazard2 = busy[q2_adr] && !(clr_en && (clr_adr == q2_adr));

endmodule

// File: rtl/regfile_port_master.sv
// rtl/regfile_port_master.sv - drives register file read/write ports for operand fetch
module regfile_port_master
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W = cpu_rf_pkg::DATA_W,
  parameter int ADR_W  = cpu_rf_pkg::ADR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [ADR_W-1:0]  op_src1,
  input  logic [ADR_W-1:0]  op_src2,
  input  logic [ADR_W-1:0]  op_dst,
  input  logic              op_has_dst,
  input  logic              wb_valid,
  input  logic [ADR_W-1:0]  wb_adr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_read_en,
  output logic [ADR_W-1:0]  rf_read_adr1,
  output logic [ADR_W-1:0]  rf_read_adr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic              rf_write_en,
  output logic [ADR_W-1:0]  rf_write_adr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              opnd_valid,
  input  logic              opnd_ready,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  output logic [ADR_W-1:0]  opnd_dst
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t state;
  state_t state_n;

  logic [ADR_W-1:0]  src1_q;
  logic [ADR_W-1:0]  src2_q;
  logic [ADR_W-1:0]  dst_q;
  logic [CNT_W-1:0]  cnt;
  logic              byp_a_hit;
  logic              byp_b_hit;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;

  logic              hazard1;
  logic              hazard2;
  logic              accept;
  logic              capture;
  logic              track;
  logic [ADR_W-1:0]  cur_src1;
  logic [ADR_W-1:0]  cur_src2;
  logic              hit1;
  logic              hit2;

  assign accept  = op_valid && op_ready;
  assign capture = (state == WAIT) && (cnt == '0);
  // Bypass window runs from the read cycle up to, but not including, capture.
  assign track   = (state == READ) || ((state == WAIT) && !capture);

  // In IDLE the request is not latched yet, so compare against the live sources.
  assign cur_src1 = (state == IDLE) ? op_src1 : src1_q;
  assign cur_src2 = (state == IDLE) ? op_src2 : src2_q;
  assign hit1     = wb_valid && (wb_adr == cur_src1);
  assign hit2     = wb_valid && (wb_adr == cur_src2);

  rf_scoreboard #(.AW(ADR_W)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && op_has_dst),
    .set_adr (op_dst),
    .clr_en  (wb_valid),
    .clr_adr (wb_adr),
    .q1_adr  (op_src1),
    .q2_adr  (op_src2),
    .hazard1 (hazard1),
    .hazard2 (hazard2)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic: one read cycle, RD_LAT-cycle wait, hold until consumed.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)     state_n = READ;
      READ:                    state_n = WAIT;
      WAIT:    if (cnt == '0)  state_n = OUT;
      OUT:     if (opnd_ready) state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  // Port outputs; everything is held at zero while reset is asserted.
  always_comb begin
    op_ready      = 1'b0;
    rf_read_en    = 1'b0;
    rf_read_adr1  = '0;
    rf_read_adr2  = '0;
    opnd_valid    = 1'b0;
    rf_write_en   = 1'b0;
    rf_write_adr  = '0;
    rf_write_data = '0;
    if (reset) begin
      op_ready      = (state == IDLE) && !hazard1 && !hazard2;
      rf_read_en    = (state == READ);
      rf_read_adr1  = (state == READ) ? src1_q : '0;
      rf_read_adr2  = (state == READ) ? src2_q : '0;
      opnd_valid    = (state == OUT);
      rf_write_en   = wb_valid;
      rf_write_adr  = wb_adr;
      rf_write_data = wb_data;
    end
  end

  // Request latch, wait counter, writeback bypass capture and operand registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src1_q    <= '0;
      src2_q    <= '0;
      dst_q     <= '0;
      cnt       <= '0;
      byp_a_hit <= 1'b0;
      byp_b_hit <= 1'b0;
      byp_a     <= '0;
      byp_b     <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      opnd_dst  <= '0;
    end else begin
      if (accept) begin
        src1_q    <= op_src1;
        src2_q    <= op_src2;
        dst_q     <= op_dst;
        byp_a_hit <= hit1;
        byp_b_hit <= hit2;
        byp_a     <= wb_data;
        byp_b     <= wb_data;
      end else if (track) begin
        if (hit1) begin
          byp_a_hit <= 1'b1;
          byp_a     <= wb_data;
        end
        if (hit2) begin
          byp_b_hit <= 1'b1;
          byp_b     <= wb_data;
        end
      end

      if (state == READ) begin
        cnt <= CNT_W'(RD_LAT - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      // A writeback in the capture cycle is newer than anything the read returned.
      if (capture) begin
        opnd_a   <= hit1 ? wb_data : (byp_a_hit ? byp_a : rf_read_data1);
        opnd_b   <= hit2 ? wb_data : (byp_b_hit ? byp_b : rf_read_data2);
        opnd_dst <= dst_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_master.sv
// tb/tb_regfile_port_master.sv - directed self-checking bench for regfile_port_master
module tb_regfile_port_master;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_src1;
  logic [1:0]  op_src2;
  logic [1:0]  op_dst;
  logic        op_has_dst;
  logic        wb_valid;
  logic [1:0]  wb_adr;
  logic [15:0] wb_data;
  logic        rf_read_en;
  logic [1:0]  rf_read_adr1;
  logic [1:0]  rf_read_adr2;
  logic [15:0] rf_read_data1;
  logic [15:0] rf_read_data2;
  logic        rf_write_en;
  logic [1:0]  rf_write_adr;
  logic [15:0] rf_write_data;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;
  logic [1:0]  opnd_dst;

  int total;
  int bad;

  logic [15:0] mem [4];

  regfile_port_master #(.DATA_W(16), .ADR_W(2), .RD_LAT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_src1       (op_src1),
    .op_src2       (op_src2),
    .op_dst        (op_dst),
    .op_has_dst    (op_has_dst),
    .wb_valid      (wb_valid),
    .wb_adr        (wb_adr),
    .wb_data       (wb_data),
    .rf_read_en    (rf_read_en),
    .rf_read_adr1  (rf_read_adr1),
    .rf_read_adr2  (rf_read_adr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_write_en   (rf_write_en),
    .rf_write_adr  (rf_write_adr),
    .rf_write_data (rf_write_data),
    .opnd_valid    (opnd_valid),
    .opnd_ready    (opnd_ready),
    .opnd_a        (opnd_a),
    .opnd_b        (opnd_b),
    .opnd_dst      (opnd_dst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: write on the edge, one-cycle registered read.
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_write_adr] <= rf_write_data;
    if (rf_read_en) begin
      rf_read_data1 <= mem[rf_read_adr1];
      rf_read_data2 <= mem[rf_read_adr2];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_opnd(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (opnd_valid === 1'b1) break;
      step();
    end
    chk(tag, 32'(opnd_valid), 32'd1);
  endtask

  task automatic wb(input logic [1:0] adr, input logic [15:0] data);
    wb_valid = 1'b1;
    wb_adr   = adr;
    wb_data  = data;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] s1, input logic [1:0] s2,
                        input logic [1:0] d, input logic hd);
    op_valid   = 1'b1;
    op_src1    = s1;
    op_src2    = s2;
    op_dst     = d;
    op_has_dst = hd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rf_read_data1 = '0;
    rf_read_data2 = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    reset = 1'b0; op_valid = 1'b0; op_src1 = '0; op_src2 = '0; op_dst = '0;
    op_has_dst = 1'b0; wb_valid = 1'b1; wb_adr = 2'd3; wb_data = 16'hDEAD;
    opnd_ready = 1'b1;
    step();
    step();

    // Reset state, write path forced off during reset
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_write_data", 32'(rf_write_data), 32'd0);
    chk("rst_read_en", 32'(rf_read_en), 32'd0);
    chk("rst_opnd_valid", 32'(opnd_valid), 32'd0);
    chk("rst_opnd_a", 32'(opnd_a), 32'd0);
    wb_valid = 1'b0;
    reset = 1'b1;
    step();

    // Preload through the write path
    wb(2'd0, 16'hCCCC);
    wb(2'd1, 16'hAAAA);
    wb(2'd2, 16'h5555);
    wb(2'd3, 16'h8E38);
    chk("idle_ready", 32'(op_ready), 32'd1);

    // Basic read
    set_op(2'd0, 2'd1, 2'd0, 1'b0);
    #1;
    chk("basic_ready", 32'(op_ready), 32'd1);
    step();
    op_valid = 1'b0;
    #1;
    chk("basic_read_en", 32'(rf_read_en), 32'd1);
    chk("basic_adr1", 32'(rf_read_adr1), 32'd0);
    chk("basic_adr2", 32'(rf_read_adr2), 32'd1);
    chk("basic_busy_ready", 32'(op_ready), 32'd0);
    step();
    chk("basic_read_en_drop", 32'(rf_read_en), 32'd0);
    chk("basic_not_yet_valid", 32'(opnd_valid), 32'd0);
    step();
    chk("basic_valid", 32'(opnd_valid), 32'd1);
    chk("basic_a", 32'(opnd_a), 32'hCCCC);
    chk("basic_b", 32'(opnd_b), 32'hAAAA);
    step();
    chk("basic_done_valid", 32'(opnd_valid), 32'd0);
    chk("basic_done_ready", 32'(op_ready), 32'd1);

    // Hazard stall released by a same-cycle writeback
    set_op(2'd0, 2'd0, 2'd2, 1'b1);
    step();
    op_valid = 1'b0;
    wait_opnd("haz_setup_valid");
    chk("haz_setup_a", 32'(opnd_a), 32'hCCCC);
    chk("haz_setup_dst", 32'(opnd_dst), 32'd2);
    step();
    set_op(2'd2, 2'd0, 2'd0, 1'b0);
    #1;
    chk("haz_stall0", 32'(op_ready), 32'd0);
    step();
    chk("haz_stall1", 32'(op_ready), 32'd0);
    wb_valid = 1'b1; wb_adr = 2'd2; wb_data = 16'hFFFF;
    #1;
    chk("haz_release", 32'(op_ready), 32'd1);
    chk("haz_wr_en", 32'(rf_write_en), 32'd1);
    chk("haz_wr_adr", 32'(rf_write_adr), 32'd2);
    step();
    wb_valid = 1'b0;
    op_valid = 1'b0;
    wait_opnd("haz_valid");
    chk("haz_a", 32'(opnd_a), 32'hFFFF);
    chk("haz_b", 32'(opnd_b), 32'hCCCC);
    step();

    // Writeback to a source during WAIT overrides the stale read
    set_op(2'd3, 2'd0, 2'd0, 1'b0);
    step();
    op_valid = 1'b0;
    step();
    wb_valid = 1'b1; wb_adr = 2'd3; wb_data = 16'h1234;
    #1;
    chk("byp_wr_en", 32'(rf_write_en), 32'd1);
    chk("byp_wr_adr", 32'(rf_write_adr), 32'd3);
    chk("byp_wr_data", 32'(rf_write_data), 32'h1234);
    step();
    wb_valid = 1'b0;
    chk("byp_valid", 32'(opnd_valid), 32'd1);
    chk("byp_a", 32'(opnd_a), 32'h1234);
    chk("byp_b", 32'(opnd_b), 32'hCCCC);
    step();

    // Backpressure holds operands stable
    opnd_ready = 1'b0;
    set_op(2'd1, 2'd3, 2'd1, 1'b0);
    step();
    op_valid = 1'b0;
    wait_opnd("bp_valid");
    set_op(2'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(opnd_valid), 32'd1);
      chk("bp_hold_a", 32'(opnd_a), 32'hAAAA);
      chk("bp_hold_b", 32'(opnd_b), 32'h1234);
      chk("bp_hold_dst", 32'(opnd_dst), 32'd1);
      chk("bp_hold_ready", 32'(op_ready), 32'd0);
    end
    op_valid = 1'b0;
    opnd_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(opnd_valid), 32'd0);
    chk("bp_release_ready", 32'(op_ready), 32'd1);

    // Set/clear collision on R1: set wins
    set_op(2'd0, 2'd0, 2'd1, 1'b1);
    wb_valid = 1'b1; wb_adr = 2'd1; wb_data = 16'h7777;
    step();
    wb_valid = 1'b0;
    op_valid = 1'b0;
    wait_opnd("col_valid");
    step();
    set_op(2'd1, 2'd0, 2'd0, 1'b0);
    #1;
    chk("col_stall0", 32'(op_ready), 32'd0);
    step();
    chk("col_stall1", 32'(op_ready), 32'd0);
    wb_valid = 1'b1; wb_adr = 2'd1; wb_data = 16'h4321;
    #1;
    chk("col_release", 32'(op_ready), 32'd1);
    step();
    wb_valid = 1'b0;
    op_valid = 1'b0;
    wait_opnd("col_op_valid");
    chk("col_a", 32'(opnd_a), 32'h4321);
    step();

    // Reset during WAIT abandons the request and clears busy
    set_op(2'd2, 2'd3, 2'd3, 1'b1);
    step();
    op_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_valid", 32'(opnd_valid), 32'd0);
    chk("mid_rst_read_en", 32'(rf_read_en), 32'd0);
    chk("mid_rst_ready", 32'(op_ready), 32'd0);
    chk("mid_rst_a", 32'(opnd_a), 32'd0);
    step();
    chk("mid_rst_no_emit", 32'(opnd_valid), 32'd0);
    reset = 1'b1;
    set_op(2'd3, 2'd2, 2'd2, 1'b0);
    #1;
    chk("post_rst_ready", 32'(op_ready), 32'd1);
    step();
    op_valid = 1'b0;
    wait_opnd("post_rst_valid");
    chk("post_rst_a", 32'(opnd_a), 32'h1234);
    chk("post_rst_b", 32'(opnd_b), 32'hFFFF);
    chk("post_rst_dst", 32'(opnd_dst), 32'd2);
    step();
    chk("post_rst_idle", 32'(opnd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
